// File: rtl/fmul_arb_if.sv
// Bundle of requester-side and multiplier-side signals for fmul_arb.
//
// Handshake semantics (all channels): a transfer happens on a rising clk edge
// where valid and ready are both 1. A producer holds valid and its payload
// stable until that edge; it may drop valid before the transfer, in which case
// nothing is transferred. Ready may depend combinationally on valid.
interface fmul_arb_if #(
  parameter int NREQ = 4,
  parameter int W    = 32
);
  logic [NREQ-1:0]   req_valid_i;
  logic [NREQ-1:0]   req_ready_o;
  logic [NREQ*W-1:0] req_a_i;
  logic [NREQ*W-1:0] req_b_i;
  logic [NREQ*3-1:0] req_rm_i;
  logic              fmul_valid_o;
  logic [W-1:0]      fmul_a_o;
  logic [W-1:0]      fmul_b_o;
  logic [2:0]        fmul_rm_o;
  logic              pipe_en_o;
  logic [W-1:0]      fmul_result_i;
  logic [4:0]        fmul_fflags_i;
  logic [NREQ-1:0]   resp_valid_o;
  logic [NREQ-1:0]   resp_ready_i;
  logic [W-1:0]      resp_result_o;
  logic [4:0]        resp_fflags_o;
  logic              busy_o;

  // Arbiter view
  modport slave (
    input  req_valid_i, req_a_i, req_b_i, req_rm_i,
    input  fmul_result_i, fmul_fflags_i, resp_ready_i,
    output req_ready_o, fmul_valid_o, fmul_a_o, fmul_b_o, fmul_rm_o,
    output pipe_en_o, resp_valid_o, resp_result_o, resp_fflags_o, busy_o
  );

  // Requesters + multiplier view
  modport master (
    output req_valid_i, req_a_i, req_b_i, req_rm_i,
    output fmul_result_i, fmul_fflags_i, resp_ready_i,
    input  req_ready_o, fmul_valid_o, fmul_a_o, fmul_b_o, fmul_rm_o,
    input  pipe_en_o, resp_valid_o, resp_result_o, resp_fflags_o, busy_o
  );
endinterface

// File: rtl/fmul_arb.sv
// Round-robin arbiter sharing one fixed-latency FP32 multiplier among NREQ
// requesters. A shift-register tracker follows each in-flight op's requester
// ID so the result can be steered back; a stalled output freezes the whole
// pipeline through the single global stage enable.
module fmul_arb #(
  parameter int NREQ      = 4,
  parameter int IDW       = 2,
  parameter int LATENCY   = 3,
  parameter int EXPWIDTH  = 8,
  parameter int PRECISION = 24
) (
  input logic      clk,
  input logic      rst,
  fmul_arb_if.slave bus
);
  localparam int W = EXPWIDTH + PRECISION;

  logic [LATENCY-1:0] vld_q, vld_d;
  logic [IDW-1:0]     id_q [LATENCY];
  logic [IDW-1:0]     id_d [LATENCY];
  logic [IDW-1:0]     ptr_q, ptr_d;

  logic               out_v;
  logic [IDW-1:0]     out_id;
  logic               out_rdy;
  logic               pipe_en;
  logic               any_req;
  logic               issue;
  logic [IDW-1:0]     gnt_id;
  logic [IDW-1:0]     cand;
  logic [IDW-1:0]     sel_id;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    resp_valid;
  logic [W-1:0]       mux_a, mux_b;
  logic [2:0]         mux_rm;

  assign out_v  = vld_q[LATENCY-1];
  assign out_id = id_q[LATENCY-1];

  // Readiness of the requester owning the result at the output stage
  always_comb begin
    out_rdy = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (out_id == IDW'(i)) out_rdy = bus.resp_ready_i[i];
    end
  end

  // Gating with rst keeps every handshake quiet while reset is held
  assign pipe_en = !rst && (!out_v || out_rdy);
  assign issue   = pipe_en && any_req;

  // Round-robin scan starting at ptr_q; first valid requester wins
  always_comb begin
    gnt_id  = '0;
    any_req = 1'b0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(ptr_q) + k) % NREQ);
      for (int j = 0; j < NREQ; j++) begin
        if (!any_req && cand == IDW'(j) && bus.req_valid_i[j]) begin
          any_req = 1'b1;
          gnt_id  = cand;
        end
      end
    end
  end

  // Grant decode and operand mux (requester 0 fields when idle)
  always_comb begin
    req_ready = '0;
    sel_id    = issue ? gnt_id : '0;
    mux_a     = '0;
    mux_b     = '0;
    mux_rm    = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (issue && gnt_id == IDW'(j)) req_ready[j] = 1'b1;
      if (sel_id == IDW'(j)) begin
        mux_a  = bus.req_a_i[j*W +: W];
        mux_b  = bus.req_b_i[j*W +: W];
        mux_rm = bus.req_rm_i[j*3 +: 3];
      end
    end
  end

  // One-hot response valid steered by the output-stage ID
  always_comb begin
    resp_valid = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (!rst && out_v && out_id == IDW'(j)) resp_valid[j] = 1'b1;
    end
  end

  // Tracker and pointer next state: advance only on enabled cycles
  always_comb begin
    vld_d = vld_q;
    id_d  = id_q;
    ptr_d = ptr_q;
    if (pipe_en) begin
      vld_d[0] = issue;
      id_d[0]  = gnt_id;
      for (int k = 1; k < LATENCY; k++) begin
        vld_d[k] = vld_q[k-1];
        id_d[k]  = id_q[k-1];
      end
      if (issue) ptr_d = IDW'((int'(gnt_id) + 1) % NREQ);
    end
  end

  // State registers; reset drops every in-flight op
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      ptr_q <= '0;
      for (int k = 0; k < LATENCY; k++) id_q[k] <= '0;
    end else begin
      vld_q <= vld_d;
      id_q  <= id_d;
      ptr_q <= ptr_d;
    end
  end

  assign bus.req_ready_o   = req_ready;
  assign bus.fmul_valid_o  = issue;
  assign bus.fmul_a_o      = mux_a;
  assign bus.fmul_b_o      = mux_b;
  assign bus.fmul_rm_o     = mux_rm;
  assign bus.pipe_en_o     = pipe_en;
  assign bus.resp_valid_o  = resp_valid;
  assign bus.resp_result_o = bus.fmul_result_i;
  assign bus.resp_fflags_o = bus.fmul_fflags_i;
  assign bus.busy_o        = |vld_q;
endmodule

// File: tb/tb_fmul_arb.sv
// Bench for fmul_arb: a stand-in FP32 multiplier pipeline, randomized
// requesters, and an in-flight op list (ordered by age) as the reference.
module tb_fmul_arb;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int LAT  = 3;
  localparam int W    = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fmul_arb_if #(.NREQ(NREQ), .W(W)) bus();

  fmul_arb #(
    .NREQ(NREQ), .IDW(IDW), .LATENCY(LAT), .EXPWIDTH(8), .PRECISION(24)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- stimulus state ----------------
  logic [NREQ-1:0] req_v;
  logic [NREQ-1:0] resp_rdy;
  logic [W-1:0]    a_v  [NREQ];
  logic [W-1:0]    b_v  [NREQ];
  logic [2:0]      rm_v [NREQ];

  // Truncating FP32 multiply for normal operands
  function automatic logic [31:0] fmul_model(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [8:0]  e;
    logic [22:0] m;
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = {1'b0, a[30:23]} + {1'b0, b[30:23]} - 9'd127;
    if (p[47]) begin
      e = e + 9'd1;
      m = p[46:24];
    end else begin
      m = p[45:23];
    end
    return {a[31] ^ b[31], e[7:0], m};
  endfunction

  function automatic logic [31:0] rand_fp();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
  endfunction

  // Stand-in multiplier: LAT stages, all gated by pipe_en_o
  logic [W-1:0] st_res [LAT];
  logic [4:0]   st_flg [LAT];
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) begin
        st_res[k] <= '0;
        st_flg[k] <= '0;
      end
    end else if (bus.pipe_en_o) begin
      st_res[0] <= fmul_model(bus.fmul_a_o, bus.fmul_b_o);
      st_flg[0] <= {2'b00, bus.fmul_rm_o};
      for (int k = 1; k < LAT; k++) begin
        st_res[k] <= st_res[k-1];
        st_flg[k] <= st_flg[k-1];
      end
    end
  end
  assign bus.fmul_result_i = st_res[LAT-1];
  assign bus.fmul_fflags_i = st_flg[LAT-1];

  // ---------------- scoreboard / reference ----------------
  logic [W-1:0] exp_q [$];   // expected results of in-flight ops, oldest first
  logic [4:0]   flg_q [$];
  int           id_mq [$];
  int           age_q [$];   // enabled edges since acceptance
  int           mptr;
  bit           m_out, m_en, m_issue, m_any;
  int           m_w;
  int           n_checks, n_fail, n_in, n_out;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive();
    bus.req_valid_i  = req_v;
    bus.resp_ready_i = resp_rdy;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a_i[i*W +: W]  = a_v[i];
      bus.req_b_i[i*W +: W]  = b_v[i];
      bus.req_rm_i[i*3 +: 3] = rm_v[i];
    end
  endtask

  // Apply inputs, then at the falling edge compare everything to the reference
  task automatic sample();
    logic [NREQ-1:0] e_rdy, e_rv;
    int j;
    drive();
    @(negedge clk);
    if (rst) begin
      m_en = 0; m_issue = 0; m_out = 0;
      check_eq("rst_req_ready", bus.req_ready_o, 0);
      check_eq("rst_fmul_valid", bus.fmul_valid_o, 0);
      check_eq("rst_pipe_en", bus.pipe_en_o, 0);
      check_eq("rst_resp_valid", bus.resp_valid_o, 0);
      return;
    end
    m_out = (age_q.size() > 0) && (age_q[0] == LAT);
    m_en  = !m_out || resp_rdy[id_mq[0]];
    m_any = 0;
    m_w   = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (mptr + k) % NREQ;
      if (!m_any && req_v[j]) begin
        m_any = 1;
        m_w   = j;
      end
    end
    m_issue = m_en && m_any;
    e_rdy = m_issue ? (NREQ'(1) << m_w) : '0;
    e_rv  = m_out ? (NREQ'(1) << id_mq[0]) : '0;
    check_eq("pipe_en", bus.pipe_en_o, m_en);
    check_eq("req_ready", bus.req_ready_o, e_rdy);
    check_eq("fmul_valid", bus.fmul_valid_o, m_issue);
    if (m_issue) begin
      check_eq("fmul_a", bus.fmul_a_o, a_v[m_w]);
      check_eq("fmul_b", bus.fmul_b_o, b_v[m_w]);
      check_eq("fmul_rm", bus.fmul_rm_o, rm_v[m_w]);
    end
    check_eq("resp_valid", bus.resp_valid_o, e_rv);
    if (m_out) begin
      check_eq("resp_result", bus.resp_result_o, exp_q[0]);
      check_eq("resp_fflags", bus.resp_fflags_o, flg_q[0]);
    end
    check_eq("busy", bus.busy_o, exp_q.size() > 0);
    check_eq("ptr", dut.ptr_q, mptr);
    if (|(bus.resp_valid_o & bus.resp_ready_i)) n_out++;
  endtask

  // Rising edge: move the reference forward exactly as the spec's rules say
  task automatic advance();
    @(posedge clk);
    if (rst) begin
      exp_q.delete(); flg_q.delete(); id_mq.delete(); age_q.delete();
      mptr = 0;
    end else if (m_en) begin
      if (m_out) begin
        void'(exp_q.pop_front()); void'(flg_q.pop_front());
        void'(id_mq.pop_front()); void'(age_q.pop_front());
      end
      foreach (age_q[i]) age_q[i]++;
      if (m_issue) begin
        exp_q.push_back(fmul_model(a_v[m_w], b_v[m_w]));
        flg_q.push_back({2'b00, rm_v[m_w]});
        id_mq.push_back(m_w);
        age_q.push_back(1);
        mptr = (m_w + 1) % NREQ;
        n_in++;
      end
    end
    #1;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    req_v = '0;
    resp_rdy = '1;
    while (exp_q.size() > 0 && guard < 40) begin
      sample(); advance(); guard++;
    end
    sample();
    check_eq("drain_busy", bus.busy_o, 0);
    advance();
  endtask

  // ---------------- test sequence ----------------
  logic [W-1:0] held_res;
  initial begin
    n_checks = 0; n_fail = 0; n_in = 0; n_out = 0; mptr = 0;
    req_v = '1;
    resp_rdy = '1;
    for (int i = 0; i < NREQ; i++) begin
      a_v[i]  = rand_fp();
      b_v[i]  = rand_fp();
      rm_v[i] = 3'($urandom_range(0, 4));
    end

    // Reset with every requester asking, then round-robin over all four
    repeat (2) begin sample(); advance(); end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sample();
      if (i == 0) check_eq("first_grant", bus.req_ready_o, 4'b0001);
      check_eq("rr_order", bus.req_ready_o, 64'(1) << (i % NREQ));
      check_eq("resp_onehot", $onehot0(bus.resp_valid_o), 1);
      advance();
      if (i == 0) check_eq("ptr_after_first", dut.ptr_q, 1);
      if (m_issue) begin
        a_v[m_w] = rand_fp();
        b_v[m_w] = rand_fp();
      end
    end
    drain();

    // Single requester 2: 1.5 * 2.0
    a_v[2] = 32'h3FC0_0000; b_v[2] = 32'h4000_0000; rm_v[2] = 3'd1;
    req_v = 4'b0100;
    sample();
    check_eq("single_ready", bus.req_ready_o, 4'b0100);
    advance();
    req_v = '0;
    sample(); advance();
    sample(); advance();
    sample();
    check_eq("single_resp_valid", bus.resp_valid_o, 4'b0100);
    check_eq("single_result", bus.resp_result_o, 32'h4040_0000);
    advance();
    drain();

    // Requester 1 result held at the output while its ready is low
    a_v[1] = rand_fp(); b_v[1] = rand_fp();
    held_res = fmul_model(a_v[1], b_v[1]);
    req_v = 4'b0010;
    sample(); advance();
    req_v = '0;
    resp_rdy = 4'b1101;
    sample(); advance();
    sample(); advance();
    req_v = '1;
    for (int i = 0; i < NREQ; i++) begin a_v[i] = rand_fp(); b_v[i] = rand_fp(); end
    for (int i = 0; i < 5; i++) begin
      sample();
      check_eq("stall_pipe_en", bus.pipe_en_o, 0);
      check_eq("stall_req_ready", bus.req_ready_o, 0);
      check_eq("stall_resp_valid", bus.resp_valid_o, 4'b0010);
      check_eq("stall_result_held", bus.resp_result_o, held_res);
      advance();
    end
    resp_rdy = '1;
    sample();
    check_eq("release_pipe_en", bus.pipe_en_o, 1);
    check_eq("release_issue", bus.fmul_valid_o, 1);
    check_eq("release_resp", bus.resp_valid_o, 4'b0010);
    advance();
    drain();

    // Randomized back-to-back traffic with toggling then random readiness
    n_in = 0; n_out = 0;
    for (int c = 0; c < 200; c++) begin
      resp_rdy = (c < 100) ? ((c % 2 == 0) ? 4'b1111 : 4'b0000) : 4'($urandom);
      for (int j = 0; j < NREQ; j++) begin
        if (!req_v[j]) begin
          if ($urandom_range(0, 2) != 0) begin
            req_v[j] = 1'b1;
            a_v[j]   = rand_fp();
            b_v[j]   = rand_fp();
            rm_v[j]  = 3'($urandom_range(0, 4));
          end
        end else if ($urandom_range(0, 15) == 0) begin
          req_v[j] = 1'b0;
        end
      end
      sample();
      check_eq("resp_onehot", $onehot0(bus.resp_valid_o), 1);
      advance();
      if (m_issue) req_v[m_w] = 1'b0;
    end
    drain();
    check_eq("count_in_out", n_out, n_in);

    // Reset with three ops in flight
    req_v = '1;
    resp_rdy = '1;
    repeat (3) begin sample(); advance(); end
    rst = 1'b1;
    sample(); advance();
    rst = 1'b0;
    req_v = '0;
    sample();
    check_eq("post_rst_busy", bus.busy_o, 0);
    check_eq("post_rst_resp_valid", bus.resp_valid_o, 0);
    check_eq("post_rst_ptr", dut.ptr_q, 0);
    advance();

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end
endmodule

// File: doc/fmul_arb.md
Name: fmul_arb

Overview:
- Shares one fixed-latency FP32 multiplier pipeline (stages s1..sLATENCY, including the s2 pass-through stage) among NREQ tensor-lane requesters.
- Round-robin arbitrates issue and drives a single global stage-enable to all pipeline registers.
- Tracks the requester ID of every in-flight op and routes each result back with per-requester backpressure.
- Sits between tensor lane operand collectors and the fmul stage chain.

Parameters:
NREQ, 4, number of requesters (>=2)
IDW, 2, requester ID width, >= clog2(NREQ)
LATENCY, 3, pipeline register stages from fmul input to fmul_result (>=1)
EXPWIDTH, 8, exponent width
PRECISION, 24, significand width incl. hidden bit; operand width W = EXPWIDTH+PRECISION

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid_i  in  NREQ  per-requester op valid
req_ready_o  out  NREQ  per-requester accept (one-hot or zero)
req_a_i  in  NREQ*W  operand A, requester i at [i*W +: W]
req_b_i  in  NREQ*W  operand B, same packing
req_rm_i  in  NREQ*3  rounding mode per requester
fmul_valid_o  out  1  op presented to stage 1
fmul_a_o  out  W  muxed operand A
fmul_b_o  out  W  muxed operand B
fmul_rm_o  out  3  muxed rounding mode
pipe_en_o  out  1  enable for every fmul stage register
fmul_result_i  in  W  result from last stage
fmul_fflags_i  in  5  exception flags from last stage
resp_valid_o  out  NREQ  one-hot result valid
resp_ready_i  in  NREQ  per-requester result accept
resp_result_o  out  W  result, broadcast
resp_fflags_o  out  5  flags, broadcast
busy_o  out  1  any op in flight

Behaviour:
- Tracker state: vld_q[0..LATENCY-1] and id_q[0..LATENCY-1] (IDW each). Round-robin pointer ptr_q (IDW).
- Reset: all vld_q=0, id_q=0, ptr_q=0. While rst=1, req_ready_o=0, fmul_valid_o=0, pipe_en_o=0, resp_valid_o=0 regardless of inputs.
- Output stage: out_v = vld_q[LATENCY-1], out_id = id_q[LATENCY-1].
- pipe_en_o = !out_v | resp_ready_i[out_id]. Combinational, no added latency.
- Arbitration is combinational.
  - Scan req_valid_i starting at ptr_q, wrapping mod NREQ; the first set bit wins (gnt_id).
  - issue = pipe_en_o & |req_valid_i.
  - req_ready_o[gnt_id] = issue; all other bits 0.
- fmul_valid_o = issue. fmul_a_o, fmul_b_o, fmul_rm_o are muxed by gnt_id (drive requester 0 fields when nothing is issued).
- On a clk edge with pipe_en_o=1:
  - vld_q[0]<=issue, id_q[0]<=gnt_id.
  - vld_q[k]<=vld_q[k-1] and id_q[k]<=id_q[k-1] for k>=1.
  - If issue, ptr_q<=(gnt_id+1) mod NREQ.
- On a clk edge with pipe_en_o=0: tracker and ptr_q hold. No issue occurs, since req_ready_o=0.
- Latency: an op accepted at edge T appears at the output stage after LATENCY enabled edges. Minimum is LATENCY cycles.
- resp_valid_o = out_v one-hot at out_id. resp_result_o=fmul_result_i, resp_fflags_o=fmul_fflags_i.
- Result held stable while resp_valid_o=1 and resp_ready_i[out_id]=0; the whole pipeline stalls.
- Simultaneous accept of the output and issue of a new op in the same cycle: legal. Full throughput is 1 op/cycle.
- Readiness of requesters other than out_id is ignored.
- busy_o = |vld_q.
- Reset mid-operation: all in-flight ops are dropped, with no response generated.
- Requester handshake: req_valid_i/operands must be held until accepted. Deasserting before accept is allowed (no op issued).

Test Plan:
1. Reset with all req_valid_i=4'b1111 → during rst: req_ready_o=0, fmul_valid_o=0. First cycle after: req_ready_o=4'b0001, ptr_q becomes 1.
2. req_valid_i=4'b1111 held for 8 cycles, resp_ready_i all 1 → grants 0,1,2,3,0,1,2,3. Responses appear 3 cycles after each grant, in the same ID order. resp_valid_o one-hot each cycle.
3. Single requester 2, a=0x3FC00000 (1.5), b=0x40000000 (2.0), fmul model connected → resp_valid_o=4'b0100 exactly 3 cycles later, resp_result_o=0x40400000.
4. Requester 1 result at output with resp_ready_i[1]=0 for 5 cycles → pipe_en_o=0, req_ready_o=0, resp_result_o stable. On release, the result is accepted and a new issue happens in the same cycle.
5. Back-to-back ops with resp_ready_i toggling 1010... → no lost or duplicated responses; count in == count out; busy_o falls 0 after the last accept.
6. rst asserted with 3 ops in flight → next cycle: busy_o=0, resp_valid_o=0, ptr_q=0.
